ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
// - AHB-Lite slave endpoint consuming the bus signals carried by the wrap interface.
// - Word-organised on-chip SRAM with per-byte write lanes and programmable wait states.
// - Signals ERROR with the two-cycle protocol on out-of-range or illegal-size accesses.
// - Sits directly downstream of the wrapper; one instance per HSEL bit.
// PARAMETERS
// - DEPTH        64  number of 32-bit words (1..64); byte address space = DEPTH*4.
// - WAIT_STATES  0   HREADYOUT-low cycles per OKAY data phase (0..7).
// - SEL_BIT      0   index of the HSEL bit that selects this slave (0..1).
// PORTS
// - HCLK       in   1   bus clock; all state updates on the rising edge.
// - HRESET     in   1   asynchronous, active-low reset.
// - HSEL       in   2   slave select vector; this slave uses HSEL[SEL_BIT].
// - HADDR      in   8   byte address.
// - HTRANS     in   2   0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
// - HWRITE     in   1   1 = write, 0 = read.
// - HSIZE      in   3   0 byte, 1 halfword, 2 word; values above 2 are illegal.
// - HBURST     in   3   ignored; each beat is decoded independently.
// - HPROT      in   4   ignored.
// - HMASTLOCK  in   1   ignored.
// - HWDATA     in   32  write data, valid in the data phase.
// - HREADY     in   1   bus-level ready; a transfer is accepted only when it is 1.
// - HRDATA     out  32  read data.
// - HREADYOUT  out  1   slave ready.
// - HRESP      out  1   0 OKAY, 1 ERROR.
// BEHAVIOUR
// - Reset (HRESET=0, asynchronous): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0.
//   - Captured address-phase registers clear to 0.
//   - SRAM contents are not reset.
//   - Reset asserted mid-transfer aborts the transfer; a partial write is not committed.
// - Address-phase accept: HSEL[SEL_BIT] & HREADY & HTRANS[1].
//   - On accept, HADDR, HWRITE and HSIZE are registered.
//   - IDLE/BUSY, or an unselected slave: zero-wait OKAY and no state change.
// - Error condition: HADDR >= DEPTH*4, or HSIZE > 2.
// - FSM states: IDLE, WAIT, DONE, ERR1, ERR2.
//   - IDLE: on a legal accept go to WAIT if WAIT_STATES>0, else DONE. On an error accept go to ERR1.
//   - WAIT: HREADYOUT=0, HRESP=0. A down-counter loaded with WAIT_STATES-1 moves to DONE at 0.
//   - DONE: HREADYOUT=1, HRESP=0; this is the final data-phase cycle.
//     - Write: commit HWDATA lanes on this edge.
//     - Then a new accept this cycle is handled as from IDLE; otherwise return to IDLE.
//   - ERR1: HREADYOUT=0, HRESP=1; next state ERR2.
//   - ERR2: HREADYOUT=1, HRESP=1; same next-state rules as DONE; no memory access.
// - Pipelining: a new address phase is accepted in the same cycle a data phase completes.
//   - Back-to-back zero-wait transfers therefore sustain one beat per cycle.
// - Byte lanes (little-endian):
//   - HSIZE=0: lane HADDR[1:0].
//   - HSIZE=1: lanes {HADDR[1],0} and {HADDR[1],1}.
//   - HSIZE=2: all 4 lanes.
//   - Word index = HADDR[7:2].
// - HRDATA = mem[word] in DONE when the captured transfer is a read; 0 at all other times.
//   - Read-after-write to the same address returns the new data, because the write commits at the end of DONE.
// - The address lines into memory are registered (address phase); no combinational path from HADDR to HRDATA.
// CONFIGURATION
// - AHB_SLV_ALIGN_CHECK_EN defined: an unaligned access is also an error condition.
//   - Unaligned means HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]!=0.
//   - It receives the ERR1/ERR2 response.
// - Not defined: the low address bits are masked to the size alignment and the access completes OKAY.
// TESTING
// - WAIT_STATES=0: write word 0xDEADBEEF @0x04, then read @0x04 -> OKAY, HRDATA=0xDEADBEEF, HREADYOUT never low.
// - WAIT_STATES=2: a write then a read produce exactly 2 HREADYOUT=0 cycles each, HRESP=0.
//   - Back-to-back NONSEQ writes @0x00, 0x04, 0x08 complete in order.
// - After word 0x11223344 @0x10:
//   - Byte write 0xAA @0x12 -> read @0x10 returns 0x11AA3344.
//   - Halfword write 0xBEEF @0x10 -> read returns 0x11AABEEF.
// - DEPTH=16: read @0x40 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
//   - HSIZE=3 gives the same response; memory is unchanged.
// - Word write @0x06:
//   - With the macro defined -> two-cycle ERROR.
//   - Without it -> writes word 1, OKAY.
// - Mid-WAIT, assert HRESET for 1 cycle -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the pending write is not committed.
//   - With HSEL[SEL_BIT]=0 or HTRANS=IDLE -> no response change.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with byte lanes, programmable wait states and two-cycle ERROR response.
// Define AHB_SLV_ALIGN_CHECK_EN to also reject unaligned halfword/word accesses.
module ahb_sram_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0,
    parameter int SEL_BIT     = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HSEL,
    input  logic [7:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] LIMIT   = 9'(DEPTH * 4);
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [2:0]  state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        accept;
    logic        misaligned;
    logic        reqErr;
    logic [7:0]  alignedAddr;
    logic [3:0]  laneEn;
    logic        memWe;
    logic [AW-1:0] wordIdx;
    logic [31:0] mem [DEPTH];
    logic        unusedOk;

    assign accept = HSEL[SEL_BIT] & HREADY & HTRANS[1];

`ifdef AHB_SLV_ALIGN_CHECK_EN
    assign misaligned = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign reqErr = ({1'b0, HADDR} >= LIMIT) || (HSIZE > 3'd2) || misaligned;

    // Low address bits are dropped to the transfer size so lane decode sees an aligned address.
    always_comb begin
        case (HSIZE)
            3'd1:    alignedAddr = {HADDR[7:1], 1'b0};
            3'd2:    alignedAddr = {HADDR[7:2], 2'b00};
            default: alignedAddr = HADDR;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            // IDLE, DONE and ERR2 all take a new address phase; stray encodings recover here too.
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = alignedAddr;
                    write_d = HWRITE;
                    size_d  = HSIZE[1:0];
                    if (reqErr) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'd0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    laneEn = 4'b0001 << addr_q[1:0];
            2'd1:    laneEn = addr_q[1] ? 4'b1100 : 4'b0011;
            default: laneEn = 4'b1111;
        endcase
    end

    assign wordIdx = addr_q[AW+1:2];
    assign memWe   = (state_q == ST_DONE) && write_q;

    // Write data belongs to the data phase, so lanes commit on the edge that closes DONE.
    always_ff @(posedge HCLK) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = ((state_q == ST_DONE) && !write_q) ? mem[wordIdx] : 32'd0;
    assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

    assign unusedOk = ^{HBURST, HPROT, HMASTLOCK, HSEL, HTRANS[0], addr_q};

endmodule
